// File: rtl/branch_predict_ras_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_ras_unit
//
// Next-PC predictor for the 5-stage RV32 pipeline. It combines a direct-mapped
// BTB, per-entry saturating direction counters, entry typing (COND / JUMP /
// RET), a non-speculative return-address stack and saturating performance
// counters.
//
// IF looks up the BTB and RAS combinationally and answers in the same cycle.
// ID trains the tables one cycle later with the resolved outcome.
//
// Ports
//   clk               main clock
//   rst               asynchronous reset, active-low
//   PC, inst          IF-stage fetch address and instruction word
//   is_predict_taken  redirect IF to predict_PC
//   predict_PC        predicted next PC (PC+4 when nothing is predicted)
//   upd_valid         ID holds a resolved, non-flushed control transfer
//   upd_PC, upd_inst  address and instruction word of that transfer
//   upd_taken         actual direction
//   upd_target        actual target
//   upd_mispredict    the IF prediction for it was wrong
//   cnt_ctrl          saturating count of resolved control transfers
//   cnt_miss          saturating count of mispredicted control transfers
// -----------------------------------------------------------------------------
module branch_predict_ras_unit #(
    parameter int ENTRIES   = 64,
    parameter int TAG_BITS  = 24,
    parameter int CTR_BITS  = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic [31:0] inst,
    output logic        is_predict_taken,
    output logic [31:0] predict_PC,
    input  logic        upd_valid,
    input  logic [31:0] upd_PC,
    input  logic [31:0] upd_inst,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    output logic [31:0] cnt_ctrl,
    output logic [31:0] cnt_miss
);

    localparam int IDX    = $clog2(ENTRIES);
    localparam int TAG_LO = IDX + 2;
    localparam int TAG_HI = IDX + 2 + TAG_BITS - 1;

    // The RAS arrays keep at least one slot so the declarations stay legal
    // when RAS_DEPTH is 0; RAS_ON masks every use of them in that case.
    localparam bit RAS_ON = (RAS_DEPTH > 0);
    localparam int RAS_N  = (RAS_DEPTH > 0) ? RAS_DEPTH : 1;
    localparam int RAS_PW = (RAS_N > 1) ? $clog2(RAS_N) : 1;
    localparam int RAS_CW = $clog2(RAS_N + 1);

    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        T_NONE = 2'd0,
        T_COND = 2'd1,
        T_JUMP = 2'd2,
        T_RET  = 2'd3
    } btype_e;

    // ------------------------------------------------------------------
    // Decode helpers, shared by the IF and ID sides
    // ------------------------------------------------------------------
    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic logic is_jalr(input logic [31:0] w);
        return w[6:0] == OP_JALR;
    endfunction

    function automatic logic is_call(input logic [31:0] w);
        return ((w[6:0] == OP_JAL) || is_jalr(w)) && is_link(w[11:7]);
    endfunction

    function automatic logic is_ret(input logic [31:0] w);
        return is_jalr(w) && is_link(w[19:15]) && !is_link(w[11:7]);
    endfunction

    // A jalr linking through one link register while jumping through the
    // other (coroutine swap) both consumes and produces a return address.
    function automatic logic is_pop(input logic [31:0] w);
        return is_ret(w) ||
               (is_jalr(w) && is_link(w[11:7]) && is_link(w[19:15]) &&
                (w[11:7] != w[19:15]));
    endfunction

    function automatic btype_e classify(input logic [31:0] w);
        btype_e t;
        t = T_NONE;
        if (w[6:0] == OP_BRANCH)  t = T_COND;
        else if (w[6:0] == OP_JAL) t = T_JUMP;
        else if (is_jalr(w))       t = is_ret(w) ? T_RET : T_JUMP;
        return t;
    endfunction

    // ------------------------------------------------------------------
    // Saturating arithmetic
    // ------------------------------------------------------------------
    function automatic logic [CTR_BITS-1:0] ctr_inc(input logic [CTR_BITS-1:0] c);
        return (c == {CTR_BITS{1'b1}}) ? c : c + CTR_BITS'(1);
    endfunction

    function automatic logic [CTR_BITS-1:0] ctr_dec(input logic [CTR_BITS-1:0] c);
        return (c == '0) ? c : c - CTR_BITS'(1);
    endfunction

    function automatic logic [31:0] cnt_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    function automatic logic [RAS_PW-1:0] ptr_inc(input logic [RAS_PW-1:0] p);
        return (p == RAS_PW'(RAS_N - 1)) ? '0 : p + RAS_PW'(1);
    endfunction

    function automatic logic [RAS_PW-1:0] ptr_dec(input logic [RAS_PW-1:0] p);
        return (p == '0) ? RAS_PW'(RAS_N - 1) : p - RAS_PW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic                valid_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q   [ENTRIES];
    logic [TAG_BITS-1:0] tag_q   [ENTRIES];
    logic [31:0]         tgt_q   [ENTRIES];
    btype_e              type_q  [ENTRIES];

    logic [31:0]         ras_q   [RAS_N];
    logic [RAS_PW-1:0]   top_q, top_d;
    logic [RAS_CW-1:0]   rcnt_q, rcnt_d;

    logic [31:0]         cnt_ctrl_q, cnt_ctrl_d;
    logic [31:0]         cnt_miss_q, cnt_miss_d;

    // ------------------------------------------------------------------
    // Index / tag extraction
    // ------------------------------------------------------------------
    logic [IDX-1:0]      f_idx, u_idx;
    logic [TAG_BITS-1:0] f_tag, u_tag;
    btype_e              f_cls, u_cls;

    assign f_idx = PC[IDX+1:2];
    assign u_idx = upd_PC[IDX+1:2];
    assign f_tag = PC[TAG_HI:TAG_LO];
    assign u_tag = upd_PC[TAG_HI:TAG_LO];
    assign f_cls = classify(inst);
    assign u_cls = classify(upd_inst);

    // Bits outside index/tag/opcode/register fields feed nothing.
    logic unused_bits;
    assign unused_bits = ^{PC, inst, upd_PC, upd_inst};

    // ------------------------------------------------------------------
    // BTB training
    // ------------------------------------------------------------------
    logic                u_hit;
    logic                btb_alloc;
    logic                ctr_we;
    logic                tgt_we;
    logic [CTR_BITS-1:0] ctr_d;

    always_comb begin
        u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag) &&
                    (type_q[u_idx] == u_cls) && (u_cls != T_NONE);
        btb_alloc = 1'b0;
        ctr_we    = 1'b0;
        tgt_we    = 1'b0;
        ctr_d     = ctr_q[u_idx];
        if (upd_valid && (u_cls != T_NONE)) begin
            if (u_hit) begin
                if (u_cls == T_COND) begin
                    ctr_we = 1'b1;
                    ctr_d  = upd_taken ? ctr_inc(ctr_q[u_idx]) : ctr_dec(ctr_q[u_idx]);
                    tgt_we = upd_taken;
                end else begin
                    tgt_we = 1'b1;
                end
            end else if (upd_taken) begin
                btb_alloc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (btb_alloc) begin
            valid_q[u_idx] <= 1'b1;
            ctr_q[u_idx]   <= CTR_WT;
        end else if (ctr_we) begin
            ctr_q[u_idx]   <= ctr_d;
        end
    end

    // Tag/target/type carry no reset: they are only ever read behind a set
    // valid bit, and every valid bit is set together with a fresh write of
    // all three, so stray writes while in reset are never observed.
    always_ff @(posedge clk) begin
        if (btb_alloc) begin
            tag_q[u_idx]  <= u_tag;
            type_q[u_idx] <= u_cls;
        end
        if (btb_alloc || tgt_we) begin
            tgt_q[u_idx]  <= upd_target;
        end
    end

    // ------------------------------------------------------------------
    // Return-address stack (trained from ID only)
    // ------------------------------------------------------------------
    logic              u_push, u_pop;
    logic              ras_we;
    logic [RAS_PW-1:0] ras_wptr;

    assign u_push = RAS_ON && upd_valid && is_call(upd_inst);
    assign u_pop  = RAS_ON && upd_valid && is_pop(upd_inst);

    always_comb begin
        top_d    = top_q;
        rcnt_d   = rcnt_q;
        ras_we   = 1'b0;
        ras_wptr = top_q;
        if (u_pop && (rcnt_q != '0)) begin
            if (u_push) begin
                // pop followed by push lands on the same slot: replace top
                ras_we = 1'b1;
            end else begin
                top_d  = ptr_dec(top_q);
                rcnt_d = rcnt_q - RAS_CW'(1);
            end
        end else if (u_push) begin
            // a pop on an empty stack is dropped, leaving a plain push;
            // when full the write lands on the oldest slot
            top_d    = ptr_inc(top_q);
            ras_wptr = ptr_inc(top_q);
            ras_we   = 1'b1;
            rcnt_d   = (rcnt_q == RAS_CW'(RAS_N)) ? rcnt_q : rcnt_q + RAS_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_q  <= '0;
            rcnt_q <= '0;
        end else begin
            top_q  <= top_d;
            rcnt_q <= rcnt_d;
        end
    end

    // Slots are only read while the count shows them as written.
    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_q[ras_wptr] <= upd_PC + 32'd4;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    always_comb begin
        cnt_ctrl_d = cnt_ctrl_q;
        cnt_miss_d = cnt_miss_q;
        if (upd_valid) begin
            cnt_ctrl_d = cnt_inc(cnt_ctrl_q);
            if (upd_mispredict) cnt_miss_d = cnt_inc(cnt_miss_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_ctrl_q <= '0;
            cnt_miss_q <= '0;
        end else begin
            cnt_ctrl_q <= cnt_ctrl_d;
            cnt_miss_q <= cnt_miss_d;
        end
    end

    assign cnt_ctrl = cnt_ctrl_q;
    assign cnt_miss = cnt_miss_q;

    // ------------------------------------------------------------------
    // Same-cycle prediction. Table reads see the pre-update contents, so a
    // training write to the fetched index becomes visible one cycle later.
    // ------------------------------------------------------------------
    logic f_hit;
    logic f_ret;

    always_comb begin
        f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag) &&
                (type_q[f_idx] == f_cls) && (f_cls != T_NONE);
        f_ret = (f_cls == T_RET);
        is_predict_taken = 1'b0;
        predict_PC       = PC + 32'd4;
        if (rst) begin
            if (f_ret && u_push) begin
                // the call resolving in ID this cycle has not reached the RAS yet
                is_predict_taken = 1'b1;
                predict_PC       = upd_PC + 32'd4;
            end else if (f_ret && RAS_ON && (rcnt_q != '0)) begin
                is_predict_taken = 1'b1;
                predict_PC       = ras_q[top_q];
            end else if (f_hit) begin
                predict_PC = tgt_q[f_idx];
                if (type_q[f_idx] == T_COND) begin
                    is_predict_taken = ctr_q[f_idx][CTR_BITS-1];
                end else begin
                    is_predict_taken = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_ras_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_predict_ras_unit
//
// Directed bench for branch_predict_ras_unit (default parameters). Stimulus
// steps drive inputs just after a rising edge and queue the hand-computed
// responses; a separate monitor pops the queue on the falling edge and
// compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_branch_predict_ras_unit;

    localparam logic [31:0] BEQ    = 32'h0000_0063; // beq x0,x0
    localparam logic [31:0] JAL_X1 = 32'h0000_00EF; // jal x1
    localparam logic [31:0] RET    = 32'h0000_8067; // jalr x0,0(x1)
    localparam logic [31:0] CORO   = 32'h0002_80E7; // jalr x1,0(x5)
    localparam logic [31:0] NOP    = 32'h0000_0013; // addi x0,x0,0

    localparam logic [1:0] K_TAKEN = 2'd0;
    localparam logic [1:0] K_PC    = 2'd1;
    localparam logic [1:0] K_CTRL  = 2'd2;
    localparam logic [1:0] K_MISS  = 2'd3;

    logic        clk;
    logic        rst;
    logic [31:0] PC;
    logic [31:0] inst;
    logic        is_predict_taken;
    logic [31:0] predict_PC;
    logic        upd_valid;
    logic [31:0] upd_PC;
    logic [31:0] upd_inst;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] cnt_ctrl;
    logic [31:0] cnt_miss;

    branch_predict_ras_unit dut (
        .clk              (clk),
        .rst              (rst),
        .PC               (PC),
        .inst             (inst),
        .is_predict_taken (is_predict_taken),
        .predict_PC       (predict_PC),
        .upd_valid        (upd_valid),
        .upd_PC           (upd_PC),
        .upd_inst         (upd_inst),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_mispredict   (upd_mispredict),
        .cnt_ctrl         (cnt_ctrl),
        .cnt_miss         (cnt_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // ---------------- monitor ----------------
    initial begin
        exp_t        it;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                case (it.kind)
                    K_TAKEN: act = {31'd0, is_predict_taken};
                    K_PC:    act = predict_PC;
                    K_CTRL:  act = cnt_ctrl;
                    default: act = cnt_miss;
                endcase
                n_checks++;
                if (act === it.exp) n_pass++;
                else $display("FAIL %s: actual %h required %h", it.name, act, it.exp);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] w);
        PC   = pc;
        inst = w;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] w, input logic tk,
                       input logic [31:0] tgt, input logic mp);
        upd_valid      = 1'b1;
        upd_PC         = pc;
        upd_inst       = w;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_mispredict = mp;
    endtask

    task automatic no_upd();
        upd_valid      = 1'b0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic push_exp(input string nm, input logic [1:0] k, input logic [31:0] v);
        exp_t it;
        it.name = nm;
        it.kind = k;
        it.exp  = v;
        sb_q.push_back(it);
    endtask

    task automatic exp_pred(input string nm, input logic tk, input logic [31:0] pc);
        push_exp({nm, "_taken"}, K_TAKEN, {31'd0, tk});
        push_exp({nm, "_pc"}, K_PC, pc);
    endtask

    task automatic exp_taken(input string nm, input logic tk);
        push_exp({nm, "_taken"}, K_TAKEN, {31'd0, tk});
    endtask

    task automatic exp_cnt(input string nm, input logic [31:0] c, input logic [31:0] m);
        push_exp({nm, "_cnt_ctrl"}, K_CTRL, c);
        push_exp({nm, "_cnt_miss"}, K_MISS, m);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b0;
        PC = 32'h0; inst = NOP;
        upd_valid = 1'b0; upd_PC = 32'h0; upd_inst = NOP;
        upd_taken = 1'b0; upd_target = 32'h0; upd_mispredict = 1'b0;
        step();

        // In reset: a call resolving alongside an IF ret must neither bypass
        // nor leave any trace after release.
        fetch(32'h300, RET); upd(32'h500, JAL_X1, 1'b1, 32'h900, 1'b1);
        exp_pred("in_reset", 1'b0, 32'h304); exp_cnt("in_reset", 0, 0);
        step();
        step();
        rst = 1'b1; no_upd();

        fetch(32'h100, BEQ);
        exp_pred("post_reset_beq", 1'b0, 32'h104); exp_cnt("post_reset", 0, 0);
        step();
        fetch(32'h300, RET);
        exp_pred("post_reset_ret", 1'b0, 32'h304);
        step();

        // Direction counter training on beq at 0x100
        fetch(32'h100, BEQ); upd(32'h100, BEQ, 1'b1, 32'h80, 1'b1);
        exp_pred("same_cycle_old", 1'b0, 32'h104);
        step();
        no_upd();
        exp_pred("trained_taken", 1'b1, 32'h80); exp_cnt("after_t1", 1, 1);
        step();
        upd(32'h100, BEQ, 1'b0, 32'h104, 1'b1);
        exp_pred("ctr10_taken", 1'b1, 32'h80);
        step();
        no_upd();
        exp_taken("ctr01_nt", 1'b0); exp_cnt("after_t3", 2, 2);
        step();
        upd(32'h100, BEQ, 1'b0, 32'h104, 1'b0);
        exp_taken("ctr01_nt_b", 1'b0);
        step();
        upd(32'h100, BEQ, 1'b0, 32'h104, 1'b0);
        exp_taken("ctr00_nt", 1'b0);
        step();
        no_upd();
        exp_taken("ctr00_sat", 1'b0);
        step();
        upd(32'h100, BEQ, 1'b1, 32'h80, 1'b1);
        exp_taken("ctr00_before_inc", 1'b0);
        step();
        upd(32'h100, BEQ, 1'b1, 32'h80, 1'b0);
        exp_taken("ctr01_after_inc", 1'b0);
        step();
        no_upd();
        exp_pred("ctr10_again", 1'b1, 32'h80);
        step();

        // Bypass, RAS top, JUMP hit, RET fallback to BTB
        fetch(32'h300, RET); upd(32'h200, JAL_X1, 1'b1, 32'h1000, 1'b1);
        exp_pred("bypass", 1'b1, 32'h204);
        step();
        no_upd();
        exp_pred("ras_top", 1'b1, 32'h204);
        step();
        fetch(32'h200, JAL_X1);
        exp_pred("jump_hit", 1'b1, 32'h1000);
        step();
        fetch(32'h400, NOP); upd(32'h300, RET, 1'b1, 32'h204, 1'b0);
        exp_pred("nop_fetch", 1'b0, 32'h404);
        step();
        no_upd(); fetch(32'h300, RET);
        exp_pred("ret_btb_fallback", 1'b1, 32'h204); exp_cnt("after_bypass", 8, 4);
        step();

        // Five calls into a four-deep stack, then five returns
        for (int k = 1; k <= 5; k++) begin
            fetch(32'h800, NOP); upd(32'h10 * k, JAL_X1, 1'b1, 32'h1000, 1'b0);
            exp_pred("call_if_nop", 1'b0, 32'h804);
            step();
        end
        fetch(32'h700, RET); upd(32'h600, RET, 1'b1, 32'h54, 1'b0);
        exp_pred("ret1", 1'b1, 32'h54);
        step();
        upd(32'h600, RET, 1'b1, 32'h44, 1'b0);
        exp_pred("ret2", 1'b1, 32'h44);
        step();
        upd(32'h600, RET, 1'b1, 32'h34, 1'b0);
        exp_pred("ret3", 1'b1, 32'h34);
        step();
        upd(32'h600, RET, 1'b1, 32'h24, 1'b0);
        exp_pred("ret4", 1'b1, 32'h24);
        step();
        no_upd();
        exp_pred("ret5_empty", 1'b0, 32'h704);
        step();
        fetch(32'h600, RET);
        exp_pred("ret_btb_hit", 1'b1, 32'h24);
        step();

        // Call then coroutine swap replaces the top without growing the stack
        fetch(32'h800, NOP); upd(32'h900, JAL_X1, 1'b1, 32'h5000, 1'b0);
        step();
        upd(32'hA00, CORO, 1'b1, 32'h6000, 1'b0);
        step();
        no_upd(); fetch(32'h700, RET);
        exp_pred("swap_top", 1'b1, 32'hA04);
        step();
        fetch(32'h800, NOP); upd(32'h600, RET, 1'b1, 32'hA04, 1'b0);
        step();
        no_upd(); fetch(32'h700, RET);
        exp_pred("swap_then_empty", 1'b0, 32'h704);
        step();

        // Aliasing: 0x100 and 0x200 share index 0
        fetch(32'h800, NOP); upd(32'h100, BEQ, 1'b1, 32'h80, 1'b1);
        step();
        no_upd(); fetch(32'h100, BEQ);
        exp_pred("alias_first", 1'b1, 32'h80);
        step();
        upd(32'h200, BEQ, 1'b1, 32'h280, 1'b1);
        exp_pred("alias_old_read", 1'b1, 32'h80);
        step();
        no_upd();
        exp_pred("alias_evicted", 1'b0, 32'h104);
        step();
        fetch(32'h200, BEQ);
        exp_pred("alias_new_hit", 1'b1, 32'h280);
        step();
        fetch(32'h200, JAL_X1);
        exp_pred("type_mismatch", 1'b0, 32'h204); exp_cnt("final", 22, 6);
        step();

        step();
        step();
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: actual %0d pending required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

endmodule
